fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/mips_pkg.sv | 22 ++
 rtl/if_id_reg.sv | 33 +++
 rtl/fetch_stage.sv | 120 ++++++++++++
 tb/tb_fetch_stage.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: opcodes, the NOP word, fetch FSM
// encoding and the default boot address.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    RST_S = 2'd0,
    FETCH = 2'd1,
    HELD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Clear inserts a bubble (NOP, invalid) but leaves
// pc_plus4 alone, since a bubble carries no meaningful return address.
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] instr_d,
  input  logic [31:0] pc_plus4_d,
  input  logic        valid_d,
  output logic [31:0] instr_q,
  output logic [31:0] pc_plus4_q,
  output logic        valid_q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= 32'h0;
      valid_q    <= 1'b0;
    end else if (clr) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (en) begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, single-entry skid buffer for words that land
// during a stall, and the fetch FSM driving the IF/ID register.
//
// state | meaning
// RST_S | first cycle after reset, no request, IF/ID untouched
// FETCH | request outstanding at PC, waiting for imem_ready
// HELD  | word parked in skid buffer while ID is stalled, no request
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [5:0]  op_code
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  skid_buf;
  logic [31:0]  pc_plus4;
  logic [31:0]  redirect_pc;
  logic         ifid_en;
  logic         ifid_clr;
  logic [31:0]  ifid_instr_d;

  assign pc_plus4    = pc + 32'd4;
  assign redirect_pc = branch_target & ~32'h3;
  assign imem_addr   = pc;
  assign op_code     = if_id_instr[31:26];

  always_comb begin
    ifid_en      = 1'b0;
    ifid_clr     = 1'b0;
    ifid_instr_d = (state == HELD) ? skid_buf : imem_rdata;
    case (state)
      FETCH: begin
        // a response coinciding with flush is dropped by the clear
        if (flush)                      ifid_clr = 1'b1;
        else if (imem_ready && !stall)  ifid_en  = 1'b1;
        else if (!imem_ready && !stall) ifid_clr = 1'b1;
      end
      HELD: begin
        if (flush)       ifid_clr = 1'b1;
        else if (!stall) ifid_en  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RST_S;
      pc       <= RESET_PC;
      skid_buf <= NOP_INSTR;
      imem_req <= 1'b0;
    end else begin
      case (state)
        RST_S: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (flush) begin
            pc       <= redirect_pc;
            skid_buf <= NOP_INSTR;
          end else if (imem_ready) begin
            if (stall) begin
              skid_buf <= imem_rdata;
              state    <= HELD;
              imem_req <= 1'b0;
            end else begin
              pc <= pc_plus4;
            end
          end
        end
        HELD: begin
          if (flush) begin
            pc       <= redirect_pc;
            skid_buf <= NOP_INSTR;
            state    <= FETCH;
            imem_req <= 1'b1;
          end else if (!stall) begin
            pc       <= pc_plus4;
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state    <= RST_S;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  if_id_reg u_if_id (
    .clk        (clk),
    .rst        (rst),
    .en         (ifid_en),
    .clr        (ifid_clr),
    .instr_d    (ifid_instr_d),
    .pc_plus4_d (pc_plus4),
    .valid_d    (1'b1),
    .instr_q    (if_id_instr),
    .pc_plus4_q (if_id_pc_plus4),
    .valid_q    (if_id_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, imem_ready;
  logic [31:0] branch_target, imem_rdata;
  logic        imem_req, if_id_valid;
  logic [31:0] imem_addr, if_id_instr, if_id_pc_plus4;
  logic [5:0]  op_code;

  logic        w_rst;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pc4;
  logic [5:0]  w_op;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .if_id_instr(if_id_instr),
    .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid), .op_code(op_code)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(w_rst), .stall(1'b0), .flush(1'b0),
    .branch_target(32'h0), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(1'b1), .imem_rdata(32'h2008_0005), .if_id_instr(w_instr),
    .if_id_pc_plus4(w_pc4), .if_id_valid(w_valid), .op_code(w_op)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: "live" once the post-reset cycle has passed,
  // "holding" while a fetched word waits for the stall to clear.
  logic        m_live, m_holding;
  logic [31:0] m_pc, m_buf, m_instr, m_pc4;
  logic        m_valid;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_live <= 0; m_holding <= 0; m_pc <= 32'h0; m_buf <= 32'h0;
      m_instr <= 32'h0; m_pc4 <= 32'h0; m_valid <= 0;
    end else if (!m_live) begin
      m_live <= 1;
    end else if (flush) begin
      m_pc <= {branch_target[31:2], 2'b00};
      m_instr <= 32'h0; m_valid <= 0; m_holding <= 0;
    end else if (m_holding) begin
      if (!stall) begin
        m_instr <= m_buf; m_pc4 <= m_pc + 32'd4; m_valid <= 1;
        m_pc <= m_pc + 32'd4; m_holding <= 0;
      end
    end else if (imem_ready) begin
      if (stall) begin
        m_buf <= imem_rdata; m_holding <= 1;
      end else begin
        m_instr <= imem_rdata; m_pc4 <= m_pc + 32'd4; m_valid <= 1;
        m_pc <= m_pc + 32'd4;
      end
    end else if (!stall) begin
      m_instr <= 32'h0; m_valid <= 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("m_req",   {31'b0, imem_req}, {31'b0, m_live && !m_holding});
      check("m_addr",  imem_addr, m_pc);
      check("m_instr", if_id_instr, m_instr);
      check("m_pc4",   if_id_pc_plus4, m_pc4);
      check("m_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
      check("m_op",    {26'b0, op_code}, {26'b0, m_instr[31:26]});
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1; w_rst = 1; stall = 0; flush = 0; imem_ready = 0;
    branch_target = 32'h0; imem_rdata = 32'h0;
    #2;
    check("rst_req",   {31'b0, imem_req}, 32'h0);
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_valid", {31'b0, if_id_valid}, 32'h0);
    check("rst_instr", if_id_instr, 32'h0);
    check("rst_pc4",   if_id_pc_plus4, 32'h0);
    check("wrst_addr", w_addr, 32'hFFFF_FFFC);
    step(); step();
    rst = 0; w_rst = 0;

    // RST_S -> FETCH; stall/flush asserted here must be ignored
    stall = 1; flush = 1; branch_target = 32'h0000_0100;
    step();
    stall = 0; flush = 0;
    check("first_req",  {31'b0, imem_req}, 32'h1);
    check("first_addr", imem_addr, 32'h0);
    check("first_valid", {31'b0, if_id_valid}, 32'h0);
    check("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    imem_ready = 1; imem_rdata = 32'h2008_0005;
    step();
    check("addi_pc4",   if_id_pc_plus4, 32'd4);
    check("addi_op",    {26'b0, op_code}, {26'b0, 6'b001000});
    check("addi_valid", {31'b0, if_id_valid}, 32'h1);
    check("wrap_pc4",   w_pc4, 32'h0);
    check("wrap_addr1", w_addr, 32'h0);
    imem_rdata = 32'h8C09_0004;
    step();
    check("lw_pc4",  if_id_pc_plus4, 32'd8);
    check("lw_op",   {26'b0, op_code}, {26'b0, 6'b100011});
    check("lw_addr", imem_addr, 32'd8);

    // two wait states at PC=8
    imem_ready = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("wait_valid", {31'b0, if_id_valid}, 32'h0);
      check("wait_instr", if_id_instr, 32'h0);
      check("wait_addr",  imem_addr, 32'd8);
    end

    // SW arrives while stalled for 3 cycles
    imem_ready = 1; imem_rdata = 32'hAC0A_0008; stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      imem_ready = 0;
      check("held_req",   {31'b0, imem_req}, 32'h0);
      check("held_valid", {31'b0, if_id_valid}, 32'h0);
      check("held_addr",  imem_addr, 32'd8);
    end
    stall = 0;
    step();
    check("sw_instr", if_id_instr, 32'hAC0A_0008);
    check("sw_op",    {26'b0, op_code}, {26'b0, 6'b101011});
    check("sw_addr",  imem_addr, 32'd12);

    // flush beats stall and a same-cycle response
    imem_ready = 1; stall = 1; flush = 1; branch_target = 32'h0000_0043;
    imem_rdata = 32'h1234_5678;
    step();
    flush = 0; stall = 0; imem_ready = 0;
    check("flush_addr",  imem_addr, 32'h0000_0040);
    check("flush_valid", {31'b0, if_id_valid}, 32'h0);
    check("flush_instr", if_id_instr, 32'h0);
    check("flush_req",   {31'b0, imem_req}, 32'h1);

    // async reset pulse while HELD
    imem_ready = 1; stall = 1; imem_rdata = 32'h0C00_0010;
    step();
    check("pre_rst_req", {31'b0, imem_req}, 32'h0);
    #2 rst = 1;
    #1;
    check("arst_req",   {31'b0, imem_req}, 32'h0);
    check("arst_addr",  imem_addr, 32'h0);
    check("arst_instr", if_id_instr, 32'h0);
    check("arst_pc4",   if_id_pc_plus4, 32'h0);
    rst = 0; stall = 0; imem_ready = 0;
    #1;
    check("rsts_req", {31'b0, imem_req}, 32'h0);
    step();
    check("resume_req",   {31'b0, imem_req}, 32'h1);
    check("resume_addr",  imem_addr, 32'h0);
    check("resume_valid", {31'b0, if_id_valid}, 32'h0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      imem_ready    = ($urandom_range(0, 3) != 0);
      stall         = ($urandom_range(0, 3) == 0);
      flush         = ($urandom_range(0, 11) == 0);
      branch_target = $urandom;
      imem_rdata    = $urandom;
      if ($urandom_range(0, 499) == 0) rst = 1;
      step();
      rst = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
